// File: rtl/pano_button.sv
// ---------------------------------------------------------------------------
// pano_button
//   Samples the active-low Pano push button, synchronises and debounces it,
//   then classifies each press as SHORT or LONG. Classified events are handed
//   to control logic through a single-entry event register.
//
// Ports
//   SYSCLK        in   1  system clock, all logic on the rising edge
//   RESET_N       in   1  synchronous active-low reset
//   BUTTON_N      in   1  raw button pin, asynchronous, 0 = pressed
//   PRESSED       out  1  debounced button level, 1 = pressed
//   EVT_VALID     out  1  an event is pending in the holding register
//   EVT_CODE      out  2  2'b01 SHORT, 2'b10 LONG (meaningful with EVT_VALID)
//   EVT_READY     in   1  consumer accepts the pending event
//   EVT_OVERFLOW  out  1  one-cycle pulse: an event was dropped (register full)
//   fsm_state     out  2  current classifier state (0 idle, 1 held, 2 long held)
//
// Event handshake: an event transfers on every rising edge where EVT_VALID and
// EVT_READY are both 1. While EVT_VALID is 1 and EVT_READY is 0, EVT_VALID and
// EVT_CODE hold steady. EVT_VALID never depends combinationally on EVT_READY.
// ---------------------------------------------------------------------------
module pano_button #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int CNT_W           = 26
) (
  input  logic       SYSCLK,
  input  logic       RESET_N,
  input  logic       BUTTON_N,
  output logic       PRESSED,
  output logic       EVT_VALID,
  output logic [1:0] EVT_CODE,
  input  logic       EVT_READY,
  output logic       EVT_OVERFLOW,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DBC_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [1:0]       CODE_SHORT = 2'b01;
  localparam logic [1:0]       CODE_LONG  = 2'b10;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser. Reset value 1 means "released", so a button held
  // through reset shows up as a fresh press once it has been debounced.
  // -------------------------------------------------------------------------
  logic sync1;
  logic sync2;

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= BUTTON_N;
      sync2 <= sync1;
    end
  end

  logic btn;
  assign btn = ~sync2;

  // -------------------------------------------------------------------------
  // Debounce: the synchronised level must differ from PRESSED for
  // DEBOUNCE_CYCLES consecutive edges before PRESSED follows it. Any edge on
  // which the levels agree restarts the count, so short bounces are ignored.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] dbc;
  logic             level_diff;
  logic             toggle;
  logic             rise;
  logic             fall;

  assign level_diff = btn ^ PRESSED;
  assign toggle     = level_diff && (dbc == DBC_LAST);
  // rise/fall mark the edge on which PRESSED changes value.
  assign rise       = toggle && !PRESSED;
  assign fall       = toggle && PRESSED;

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      dbc     <= '0;
      PRESSED <= 1'b0;
    end else if (!level_diff) begin
      dbc <= '0;
    end else if (toggle) begin
      dbc     <= '0;
      PRESSED <= ~PRESSED;
    end else begin
      dbc <= dbc + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Press classifier
  // -------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_next;
  logic             emit;
  logic [1:0]       emit_code;

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    emit       = 1'b0;
    emit_code  = 2'b00;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_HELD;
          hold_next  = '0;
        end
      end
      ST_HELD: begin
        if (hold_cnt == LONG_LAST) begin
          // LONG wins if the release lands on the very same edge; in that case
          // go straight back to idle so the classifier does not wait for a
          // fall that has already happened. hold_cnt saturates here.
          emit       = 1'b1;
          emit_code  = CODE_LONG;
          state_next = fall ? ST_IDLE : ST_LONG_HELD;
        end else if (fall) begin
          emit       = 1'b1;
          emit_code  = CODE_SHORT;
          state_next = ST_IDLE;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        // The LONG event was already reported when the threshold was crossed.
        if (fall) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign fsm_state = state;

  // -------------------------------------------------------------------------
  // Single-entry event register. A new event is loaded whenever the register
  // is empty or is being drained on the same edge; otherwise the new event is
  // dropped and the overflow pulse is raised for one cycle.
  // -------------------------------------------------------------------------
  logic reg_full;
  assign reg_full = EVT_VALID && !EVT_READY;

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      EVT_VALID    <= 1'b0;
      EVT_CODE     <= 2'b00;
      EVT_OVERFLOW <= 1'b0;
    end else begin
      EVT_OVERFLOW <= emit && reg_full;
      if (emit) begin
        if (!reg_full) begin
          EVT_VALID <= 1'b1;
          EVT_CODE  <= emit_code;
        end
      end else if (EVT_VALID && EVT_READY) begin
        EVT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pano_button.sv
// ---------------------------------------------------------------------------
// tb_pano_button
//   Directed bench for pano_button with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
//   Inputs change 1 time unit after a rising edge; outputs are checked at the
//   same point, so each tick() shows the result of exactly one edge.
//   Timing used below: a BUTTON_N change reaches PRESSED on the 6th edge after
//   it is applied; a LONG event appears 20 edges after PRESSED rises.
// ---------------------------------------------------------------------------
module tb_pano_button;

  logic       clk;
  logic       rst_n;
  logic       button_n;
  logic       pressed;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_overflow;
  logic [1:0] fsm_state;

  int tests_run;
  int tests_failed;

  pano_button #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .CNT_W          (8)
  ) dut (
    .SYSCLK      (clk),
    .RESET_N     (rst_n),
    .BUTTON_N    (button_n),
    .PRESSED     (pressed),
    .EVT_VALID   (evt_valid),
    .EVT_CODE    (evt_code),
    .EVT_READY   (evt_ready),
    .EVT_OVERFLOW(evt_overflow),
    .fsm_state   (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pressed"}, 8'(pressed), 8'd0);
    chk({tag, "_valid"}, 8'(evt_valid), 8'd0);
    chk({tag, "_code"}, 8'(evt_code), 8'd0);
    chk({tag, "_ovf"}, 8'(evt_overflow), 8'd0);
    chk({tag, "_state"}, 8'(fsm_state), 8'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    button_n  = 1'b1;
    evt_ready = 1'b0;
    tick();

    // 1: reset with the button held, then release reset
    button_n = 1'b0;
    tick();
    tick();
    chk_all_zero("rst");
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rst_press_lat", 8'(pressed), (i == 6) ? 8'd1 : 8'd0);
    end
    chk("rst_state_held", 8'(fsm_state), 8'd1);
    button_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rst_rel_lat", 8'(pressed), (i == 6) ? 8'd0 : 8'd1);
    end
    chk("rst_short_valid", 8'(evt_valid), 8'd1);
    chk("rst_short_code", 8'(evt_code), 8'h01);
    tick();
    chk("rst_short_drain", 8'(evt_valid), 8'd0);
    tick();
    tick();

    // 2: bounce 0x3, 1x2, 0x3, then 1
    evt_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= 3 || (i >= 6 && i <= 8)) button_n = 1'b0;
      else button_n = 1'b1;
      tick();
      chk("bounce_pressed", 8'(pressed), 8'd0);
      chk("bounce_valid", 8'(evt_valid), 8'd0);
    end

    // 3: short press, consumer not ready
    button_n = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("short_pressed", 8'(pressed), (i >= 6 && i <= 15) ? 8'd1 : 8'd0);
      chk("short_valid", 8'(evt_valid), (i == 16) ? 8'd1 : 8'd0);
      if (i == 10) button_n = 1'b1;
    end
    chk("short_code", 8'(evt_code), 8'h01);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("short_hold_valid", 8'(evt_valid), 8'd1);
      chk("short_hold_code", 8'(evt_code), 8'h01);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("short_drained", 8'(evt_valid), 8'd0);
    tick();

    // 4: long press, consumer always ready
    evt_ready = 1'b1;
    button_n  = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      chk("long_pressed", 8'(pressed), (i >= 6 && i <= 45) ? 8'd1 : 8'd0);
      chk("long_valid", 8'(evt_valid), (i == 26) ? 8'd1 : 8'd0);
      if (i == 26) chk("long_code", 8'(evt_code), 8'h02);
      if (i == 40) button_n = 1'b1;
    end
    chk("long_idle", 8'(fsm_state), 8'd0);

    // 5: backpressure -- two short presses, then a long one drained on emit
    evt_ready = 1'b0;
    button_n  = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 10) button_n = 1'b1;
    end
    chk("bp_first_valid", 8'(evt_valid), 8'd1);
    chk("bp_first_code", 8'(evt_code), 8'h01);
    tick();
    tick();
    button_n = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("bp_ovf", 8'(evt_overflow), (i == 16) ? 8'd1 : 8'd0);
      chk("bp_hold_valid", 8'(evt_valid), 8'd1);
      chk("bp_hold_code", 8'(evt_code), 8'h01);
      if (i == 10) button_n = 1'b1;
    end
    tick();
    chk("bp_ovf_pulse_end", 8'(evt_overflow), 8'd0);
    button_n = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (i <= 25) begin
        chk("bp3_hold_valid", 8'(evt_valid), 8'd1);
        chk("bp3_hold_code", 8'(evt_code), 8'h01);
      end
      if (i == 25) evt_ready = 1'b1;
      if (i == 26) begin
        chk("bp3_swap_valid", 8'(evt_valid), 8'd1);
        chk("bp3_swap_code", 8'(evt_code), 8'h02);
        chk("bp3_swap_ovf", 8'(evt_overflow), 8'd0);
      end
      if (i >= 27) chk("bp3_drained", 8'(evt_valid), 8'd0);
      if (i == 30) button_n = 1'b1;
    end

    // 6: reset part-way through a press, button kept down
    tick();
    evt_ready = 1'b1;
    button_n  = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("mid_valid", 8'(evt_valid), 8'd0);
    end
    chk("mid_state_held", 8'(fsm_state), 8'd1);
    rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero("mid_rst");
    rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("mid_re_pressed", 8'(pressed), (i >= 6) ? 8'd1 : 8'd0);
      chk("mid_re_valid", 8'(evt_valid), (i == 26) ? 8'd1 : 8'd0);
      if (i == 26) chk("mid_re_code", 8'(evt_code), 8'h02);
    end
    button_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("mid_rel_valid", 8'(evt_valid), 8'd0);
    end
    chk("mid_rel_pressed", 8'(pressed), 8'd0);
    chk("mid_rel_state", 8'(fsm_state), 8'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
